// File: rtl/lane_accum_pkg.sv
// Shared types and helpers for lane_accum: mode encoding, width adaptation, lane slicing.
package lane_accum_pkg;

  localparam int unsigned ADAPT_MAX_W = 64;

  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_ACC  = 1'b1
  } mode_e;

  // Keeps the low to_w bits of a zero-extended value: truncates or zero-extends.
  function automatic logic [ADAPT_MAX_W-1:0] width_adapt(input logic [ADAPT_MAX_W-1:0] v,
                                                         input int unsigned to_w);
    logic [ADAPT_MAX_W-1:0] mask;
    mask = (to_w >= ADAPT_MAX_W) ? '1
                                 : ((ADAPT_MAX_W'(1) << to_w) - ADAPT_MAX_W'(1));
    return v & mask;
  endfunction

  function automatic int unsigned lane_b_lo(input int unsigned lane, input int unsigned in_w);
    return lane * 2 * in_w;
  endfunction

  function automatic int unsigned lane_a_lo(input int unsigned lane, input int unsigned in_w);
    return lane * 2 * in_w + in_w;
  endfunction

endpackage

// File: rtl/lane_accum_add.sv
// lane_add: combinational per-lane adder with operand and result width adaptation.
module lane_add
  import lane_accum_pkg::*;
#(
  parameter int unsigned IN_W   = 5,
  parameter int unsigned LANE_W = 3,
  parameter int unsigned OUT_W  = 6
) (
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic [OUT_W-1:0] s
);

  logic [LANE_W-1:0] a_l;
  logic [LANE_W-1:0] b_l;
  logic [LANE_W-1:0] sum_l;

  always_comb begin
    a_l   = LANE_W'(width_adapt(ADAPT_MAX_W'(a), LANE_W));
    b_l   = LANE_W'(width_adapt(ADAPT_MAX_W'(b), LANE_W));
    sum_l = a_l + b_l;
    s     = OUT_W'(width_adapt(ADAPT_MAX_W'(sum_l), OUT_W));
  end

endmodule

// File: rtl/lane_accum.sv
// Multi-lane adder/accumulator, two-stage valid/ready pipeline.
// LANE_ACCUM_SAT_EN: accumulate overflow saturates instead of wrapping.
module lane_accum
  import lane_accum_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned IN_W   = 5,
  parameter int unsigned LANE_W = 3,
  parameter int unsigned OUT_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*2*IN_W-1:0] in_data,
  input  logic                    mode,
  input  logic                    clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*OUT_W-1:0]  out_data,
  output logic [LANES-1:0]        ovf
);

  logic                          s1_valid_q, s1_valid_d;
  logic [LANES-1:0][LANE_W-1:0]  s1_a_q, s1_a_d;
  logic [LANES-1:0][LANE_W-1:0]  s1_b_q, s1_b_d;
  mode_e                         s1_mode_q, s1_mode_d;
  logic                          s1_clr_q, s1_clr_d;
  logic                          out_valid_q, out_valid_d;
  logic [LANES-1:0][OUT_W-1:0]   acc_q, acc_d;
  logic [LANES-1:0]              ovf_q, ovf_d;

  logic [LANES-1:0][OUT_W-1:0]   lane_sum;
  logic [LANES-1:0][OUT_W:0]     acc_sum;
  logic                          advance;
  logic                          accept;

  assign advance   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || advance;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign ovf       = ovf_q;

  // S1 already holds LANE_W operands, so the adder's operand adapt is an identity here.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_add #(
      .IN_W   (LANE_W),
      .LANE_W (LANE_W),
      .OUT_W  (OUT_W)
    ) u_lane_add (
      .a (s1_a_q[g]),
      .b (s1_b_q[g]),
      .s (lane_sum[g])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s1_clr_d   = s1_clr_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_mode_d  = mode_e'(mode);
      s1_clr_d   = clr;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_a_d[i] = LANE_W'(width_adapt(ADAPT_MAX_W'(in_data[lane_a_lo(i, IN_W) +: IN_W]), LANE_W));
        s1_b_d[i] = LANE_W'(width_adapt(ADAPT_MAX_W'(in_data[lane_b_lo(i, IN_W) +: IN_W]), LANE_W));
      end
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    acc_sum     = '0;
    if (advance) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      acc_sum[i] = {1'b0, acc_q[i]} + {1'b0, lane_sum[i]};
      if (advance) begin
        if (s1_mode_q == MODE_LOAD || s1_clr_q) begin
          acc_d[i] = lane_sum[i];
          ovf_d[i] = 1'b0;
        end else begin
          ovf_d[i] = ovf_q[i] | acc_sum[i][OUT_W];
`ifdef LANE_ACCUM_SAT_EN
          acc_d[i] = acc_sum[i][OUT_W] ? '1 : acc_sum[i][OUT_W-1:0];
`else
          acc_d[i] = acc_sum[i][OUT_W-1:0];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= MODE_LOAD;
      s1_clr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s1_clr_q    <= s1_clr_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: doc/lane_accum.md
# lane_accum

Multi-lane, width-adapting adder/accumulator with a two-stage valid/ready pipeline. Each lane adds a pair of operands through a fixed-width lane adder. Operands and results are zero-extended or truncated at every width boundary. The lane result is either loaded into or accumulated into a per-lane register. It sits in the sv cosim suite as the sequential, parametrised successor to the instance port-size tests, and exercises port width adaptation across parameter combinations under backpressure.

## Interface
Parameters:
- LANES, 4: number of independent lanes.
- IN_W, 5: width of each incoming operand.
- LANE_W, 3: width of the lane adder's operand and result ports.
- OUT_W, 6: width of each lane's accumulator and output field.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat offered.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  LANES*2*IN_W  lane i at bits [i*2*IN_W +: 2*IN_W], packed {a_i, b_i} with a_i in the upper IN_W bits.
- mode  input  1  0 = load, 1 = accumulate; sampled with the beat.
- clr  input  1  accumulate from zero; sampled with the beat; ignored when mode=0.
- out_valid  output  1  out_data/ovf hold a result.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_data  output  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W].
- ovf  output  LANES  sticky per-lane accumulate overflow.

## Operation
- Operand adapt (IN_W→LANE_W): if IN_W<LANE_W, zero-extend; otherwise keep the low LANE_W bits.
- Lane sum: a+b modulo 2^LANE_W; the carry out is discarded.
- Result adapt (LANE_W→OUT_W): if LANE_W<OUT_W, zero-extend sum s; otherwise keep the low OUT_W bits.
- S1 registers the adapted operands plus mode and clr. S2 computes the lane sum and updates the accumulator.
- S2 update per lane at load time:
  - mode=0: acc=s, ovf=0.
  - mode=1, clr=1: acc=s, ovf=0.
  - mode=1, clr=0: acc=acc+s. Carry out of OUT_W bits sets ovf; ovf otherwise holds.
- out_data is the accumulator registers directly. It is stable while out_valid && !out_ready.
- Lanes are fully independent; there is no cross-lane carry.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, ovf=0, s1_valid=0. Reset takes effect immediately on rst_n falling and clears everything, including in-flight beats. No beat emerges after release.
- S1→S2 advance: s1_valid && (!out_valid || out_ready).
- in_ready = !s1_valid || advance. This is combinational from out_ready.
- Latency: a beat accepted at edge k gives out_valid at edge k+1 with that beat's result in out_data. The beat reaches S1 at edge k, then S2/out at the next advancing edge. Unstalled throughput is 1 beat per cycle.
- Simultaneous output consume and new load in the same cycle: the output register takes the new result, and out_valid stays 1.
- At most 2 beats are in flight (S1 plus the output register). Under stall, no beat is dropped or duplicated and order is preserved.
- The accumulator is updated only on S2 load, never on a stalled cycle.

## Configuration
- LANE_ACCUM_SAT_EN defined: an accumulate overflow clamps acc to 2^OUT_W−1, and ovf is still set. A saturated acc stays saturated on further accumulate.
- LANE_ACCUM_SAT_EN undefined: acc wraps modulo 2^OUT_W.
- Load and clr behaviour are identical in both builds.

## Structure
- lane_accum_pkg holds:
  - the mode encoding (LOAD=0, ACC=1);
  - the width-adapt function (zero-extend or truncate to a target width);
  - the lane slice index helpers.
- Sub-module lane_add (parameters IN_W, LANE_W, OUT_W) is combinational. It performs operand adapt, modular sum and result adapt, and is instantiated once per lane via generate.
- The pipeline registers, handshake and accumulators live in lane_accum.

## Test plan
All scenarios use default parameters unless stated.
- Reset: hold rst_n=0 → in_ready=1, out_valid=0, out_data=0, ovf=0.
- Truncating load:
  - lane0 a=5'h07, b=5'h01, mode=0 → lane0 out=6'd0.
  - a=5'h13, b=5'h02 → lane0 out=6'd5.
- Accumulate wrap: lane1 a=3, b=4, mode=1 with clr=1 on the first beat, 10 beats → out=6'd6, ovf[1]=1. With LANE_ACCUM_SAT_EN → out=6'd63, ovf[1]=1.
- Backpressure: out_ready=0 for 5 cycles while 3 beats are offered (mode=0) → exactly 2 beats accepted and in_ready=0. When out_ready=1, all 3 results appear in order with no duplicate.
- Clear after overflow: send mode=1, clr=1, sum 2 → out=6'd2, ovf=0.
- Mid-operation reset: drop rst_n with S1 and out valid, then release → out_valid=0, out_data=0. A following beat a=1, b=1, mode=0 gives lane out 6'd2.
- Parameter sweep: LANE_W=5, OUT_W=3, a=5'h1F, b=5'h01 → out=3'd0.
